hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 99 +++++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Load-use / branch / memory-wait hazard controller for a 5-stage in-order pipeline.
// Control outputs are decoded combinationally from the FSM state and current inputs.
module hazard_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              branch_taken,
  input  logic              mem_busy,
  input  logic              cnt_clr,
  output logic              stall_fe,
  output logic              bubble,
  output logic              flush,
  output logic              freeze,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic {
    IDLE       = 1'b0,
    LOAD_STALL = 1'b1
  } state_t;

  localparam logic [1:0]       LAT_M1  = 2'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             hit;

  // x0 is hard-wired zero, so a load targeting it can never create a dependency.
  assign hit = ex_mem_read && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    stall_fe = 1'b0;
    bubble   = 1'b0;
    flush    = 1'b0;
    freeze   = 1'b0;
    state_d  = state_q;
    rem_d    = rem_q;
    if (mem_busy) begin
      freeze = 1'b1;
    end else if (branch_taken) begin
      // A taken branch squashes the dependent instruction, so any pending load stall is moot.
      flush   = 1'b1;
      bubble  = 1'b1;
      state_d = IDLE;
      rem_d   = 2'd0;
    end else if (state_q == LOAD_STALL) begin
      stall_fe = 1'b1;
      bubble   = 1'b1;
      rem_d    = rem_q - 2'd1;
      if (rem_q == 2'd1) begin
        state_d = IDLE;
      end
    end else if (hit) begin
      stall_fe = 1'b1;
      bubble   = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d = LOAD_STALL;
        rem_d   = LAT_M1;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (cnt_clr) begin
      stall_count_d = '0;
    end else if ((stall_fe || freeze) && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rem_q         <= 2'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_LAT 1/3/2) share stimulus and are
// compared every cycle against a pending-stall-count reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, branch_taken, mem_busy, cnt_clr;
  logic [2:0] sfe, bub, fl, frz;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  always #5 clk = ~clk;

  hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .cnt_clr(cnt_clr), .stall_fe(sfe[0]), .bubble(bub[0]), .flush(fl[0]),
    .freeze(frz[0]), .stall_count(cnt0));

  hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .cnt_clr(cnt_clr), .stall_fe(sfe[1]), .bubble(bub[1]), .flush(fl[1]),
    .freeze(frz[1]), .stall_count(cnt1));

  hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(2), .CNT_W(4)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .cnt_clr(cnt_clr), .stall_fe(sfe[2]), .bubble(bub[2]), .flush(fl[2]),
    .freeze(frz[2]), .stall_count(cnt2));

  int errors = 0;
  int checks = 0;

  int lat[3]    = '{1, 3, 2};
  int cmax[3]   = '{65535, 65535, 15};
  int pend[3];
  int mcnt[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int k);
    case (k)
      0:       return {16'd0, cnt0};
      1:       return {16'd0, cnt1};
      default: return {28'd0, cnt2};
    endcase
  endfunction

  task automatic drive(input int rs1, input int rs2, input int u1, input int u2,
                       input int rd, input int mr, input int br, input int mb, input int clr);
    id_rs1       = 5'(rs1);
    id_rs2       = 5'(rs2);
    id_use_rs1   = (u1 != 0);
    id_use_rs2   = (u2 != 0);
    ex_rd        = 5'(rd);
    ex_mem_read  = (mr != 0);
    branch_taken = (br != 0);
    mem_busy     = (mb != 0);
    cnt_clr      = (clr != 0);
  endtask

  // One clock cycle: apply inputs, check the decoded controls, then check the counter after the edge.
  task automatic step(input int rs1, input int rs2, input int u1, input int u2,
                      input int rd, input int mr, input int br, input int mb, input int clr);
    int  npend[3];
    int  ncnt[3];
    bit  hit, e_sfe, e_bub, e_fl, e_frz;
    @(negedge clk);
    drive(rs1, rs2, u1, u2, rd, mr, br, mb, clr);
    #1;
    hit = (mr != 0) && (rd != 0) && (((u1 != 0) && rs1 == rd) || ((u2 != 0) && rs2 == rd));
    for (int k = 0; k < 3; k++) begin
      e_sfe = 0; e_bub = 0; e_fl = 0; e_frz = 0;
      npend[k] = pend[k];
      if (mb != 0) begin
        e_frz = 1;
      end else if (br != 0) begin
        e_fl = 1; e_bub = 1; npend[k] = 0;
      end else if (pend[k] > 0) begin
        e_sfe = 1; e_bub = 1; npend[k] = pend[k] - 1;
      end else if (hit) begin
        e_sfe = 1; e_bub = 1; npend[k] = lat[k] - 1;
      end
      if (clr != 0)                                      ncnt[k] = 0;
      else if ((e_sfe || e_frz) && mcnt[k] < cmax[k])    ncnt[k] = mcnt[k] + 1;
      else                                               ncnt[k] = mcnt[k];
      chk($sformatf("stall_fe[%0d]", k), {31'd0, sfe[k]}, {31'd0, e_sfe});
      chk($sformatf("bubble[%0d]", k),   {31'd0, bub[k]}, {31'd0, e_bub});
      chk($sformatf("flush[%0d]", k),    {31'd0, fl[k]},  {31'd0, e_fl});
      chk($sformatf("freeze[%0d]", k),   {31'd0, frz[k]}, {31'd0, e_frz});
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      pend[k] = npend[k];
      mcnt[k] = ncnt[k];
      chk($sformatf("stall_count[%0d]", k), dut_cnt(k), 32'(mcnt[k]));
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic hazard(input int br);
    step(5, 0, 1, 0, 5, 1, br, 0, 0);
  endtask

  // Asserts reset away from the clock edge and checks its effect is immediate.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int k = 0; k < 3; k++) begin
      pend[k] = 0;
      mcnt[k] = 0;
      chk($sformatf("rst_stall_fe[%0d]", k), {31'd0, sfe[k]}, 32'd0);
      chk($sformatf("rst_bubble[%0d]", k),   {31'd0, bub[k]}, 32'd0);
      chk($sformatf("rst_flush[%0d]", k),    {31'd0, fl[k]},  32'd0);
      chk($sformatf("rst_freeze[%0d]", k),   {31'd0, frz[k]}, 32'd0);
      chk($sformatf("rst_count[%0d]", k),    dut_cnt(k), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      pend[k] = 0;
      mcnt[k] = 0;
    end
    do_reset();

    // Single load-use hazard on rs1
    hazard(0);
    idle();
    chk("lat1_single_count", {16'd0, cnt0}, 32'd1);

    // x0 never hazards; unused rs2 never hazards
    do_reset();
    step(0, 0, 1, 0, 0, 1, 0, 0, 0);
    step(0, 5, 0, 0, 5, 1, 0, 0, 0);
    chk("x0_unused_count0", {16'd0, cnt0}, 32'd0);
    chk("x0_unused_count1", {16'd0, cnt1}, 32'd0);

    // Multi-cycle stall then return to idle
    do_reset();
    hazard(0);
    idle(); idle(); idle();
    chk("lat3_count", {16'd0, cnt1}, 32'd3);
    chk("lat2_count", {28'd0, cnt2}, 32'd2);

    // Memory wait in the middle of a load stall
    do_reset();
    hazard(0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(); idle(); idle();
    chk("lat3_busy_count", {16'd0, cnt1}, 32'd5);

    // Branch beats a simultaneous hazard
    do_reset();
    hazard(1);
    idle();
    chk("branch_hit_count", {16'd0, cnt1}, 32'd0);

    // Branch cancels an in-progress stall
    hazard(0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();

    // Counter saturation and clear priority
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("sat_count", {28'd0, cnt2}, 32'd15);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("clr_count", {28'd0, cnt2}, 32'd0);

    // Reset in the middle of a load stall
    hazard(0);
    do_reset();
    idle();

    // Randomized traffic with small register range to force collisions and x0 cases
    for (int i = 0; i < 600; i++) begin
      step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 31) == 0));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
